// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the Controller (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
   parameter int TW = 3,
   parameter int SW = 2
);
   logic [4:0]    d_rs_addr;
   logic [TW-1:0] d_rs_tuse;
   logic [4:0]    d_rt_addr;
   logic [TW-1:0] d_rt_tuse;
   logic [4:0]    d_wa;
   logic          d_we;
   logic [TW-1:0] d_tnew;
   logic          d_md_start;
   logic          d_md_div;
   logic          d_md_use;
   logic          stall;
   logic [SW-1:0] fwd_rs_sel;
   logic [SW-1:0] fwd_rt_sel;
   logic [SW-1:0] e_fwd_rs_sel;
   logic [SW-1:0] e_fwd_rt_sel;
   logic          md_busy;

   modport master (
      output d_rs_addr, d_rs_tuse, d_rt_addr, d_rt_tuse, d_wa, d_we, d_tnew,
      output d_md_start, d_md_div, d_md_use,
      input  stall, fwd_rs_sel, fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel, md_busy
   );

   modport slave (
      input  d_rs_addr, d_rs_tuse, d_rt_addr, d_rt_tuse, d_wa, d_we, d_tnew,
      input  d_md_start, d_md_div, d_md_use,
      output stall, fwd_rs_sel, fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// T_use/T_new stall and forward unit with an NSTAGE-deep writer scoreboard behind D.
// Define HZD_MDU_EN to build the multiply/divide busy counter that stalls HI/LO users.
module hazard_scoreboard #(
   parameter int NSTAGE  = 3,
   parameter int TW      = 3,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic               clk,
   input  logic               reset,
   hazard_scoreboard_if.slave bus
);
   localparam int SW = $clog2(NSTAGE + 1);
   localparam logic [TW-1:0] TUSE_NONE = TW'(5);

   typedef struct packed {
      logic          v;
      logic [4:0]    wa;
      logic [TW-1:0] tnew;
   } entry_t;

   entry_t s_reg [1:NSTAGE];
   logic   stall;
   logic   md_hazard;
   logic   md_busy;

   // Writer pipeline: s[1] is E; older entries age one stage per cycle regardless of stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= NSTAGE; k++) begin
            s_reg[k] <= '0;
         end
      end else begin
         if (stall) begin
            s_reg[1] <= '0;
         end else begin
            s_reg[1].v    <= bus.d_we && (bus.d_wa != 5'd0);
            s_reg[1].wa   <= bus.d_wa;
            s_reg[1].tnew <= bus.d_tnew;
         end
         for (int k = 2; k <= NSTAGE; k++) begin
            s_reg[k].v    <= s_reg[k-1].v;
            s_reg[k].wa   <= s_reg[k-1].wa;
            s_reg[k].tnew <= (s_reg[k-1].tnew == '0) ? '0 : s_reg[k-1].tnew - 1'b1;
         end
      end
   end

   // Operand 0 is rs, operand 1 is rt.
   for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic [4:0]    addr;
      logic [TW-1:0] tuse;
      logic          hit;
      logic [SW-1:0] hit_k;
      logic [TW-1:0] hit_tnew;
      logic          used;
      logic          hazard;
      logic [SW-1:0] fwd;
      logic [SW-1:0] efwd_reg;

      assign addr = (gi == 0) ? bus.d_rs_addr : bus.d_rt_addr;
      assign tuse = (gi == 0) ? bus.d_rs_tuse : bus.d_rt_tuse;

      // Scan oldest to youngest so the nearest matching producer overrides.
      always_comb begin
         hit      = 1'b0;
         hit_k    = '0;
         hit_tnew = '0;
         for (int k = NSTAGE; k >= 1; k--) begin
            if (s_reg[k].v && (s_reg[k].wa == addr) && (addr != 5'd0)) begin
               hit      = 1'b1;
               hit_k    = SW'(k);
               hit_tnew = s_reg[k].tnew;
            end
         end
      end

      assign used   = hit && (tuse != TUSE_NONE);
      assign hazard = used && ((tuse == '0) ? (hit_tnew != '0) : (hit_tnew > TW'(1)));
      assign fwd    = (used && (hit_tnew == '0)) ? hit_k : '0;

      // Producer one cycle from ready: by E it sits one stage further with tnew 0.
      always_ff @(posedge clk) begin
         if (reset || stall) begin
            efwd_reg <= '0;
         end else if (used && (hit_tnew == TW'(1)) && (tuse != '0)) begin
            efwd_reg <= hit_k;
         end else begin
            efwd_reg <= '0;
         end
      end
   end

`ifdef HZD_MDU_EN
   localparam int CW = $clog2(DIV_LAT + 1);
   logic [CW-1:0] md_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_reg <= '0;
      end else if (bus.d_md_start && !stall) begin
         md_cnt_reg <= bus.d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end else if (md_cnt_reg != '0) begin
         md_cnt_reg <= md_cnt_reg - 1'b1;
      end
   end

   assign md_busy   = (md_cnt_reg != '0);
   assign md_hazard = bus.d_md_use && md_busy;
`else
   logic md_unused;
   assign md_unused = bus.d_md_start ^ bus.d_md_div ^ bus.d_md_use;
   assign md_busy   = 1'b0;
   assign md_hazard = 1'b0;
`endif

   assign stall = g_op[0].hazard | g_op[1].hazard | md_hazard;

   assign bus.stall        = stall;
   assign bus.fwd_rs_sel   = g_op[0].fwd;
   assign bus.fwd_rt_sel   = g_op[1].fwd;
   assign bus.e_fwd_rs_sel = g_op[0].efwd_reg;
   assign bus.e_fwd_rt_sel = g_op[1].efwd_reg;
   assign bus.md_busy      = md_busy;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; MDU expectations follow whether HZD_MDU_EN is defined.
module tb_hazard_scoreboard;
`ifdef HZD_MDU_EN
   localparam logic MDU_ON = 1'b1;
`else
   localparam logic MDU_ON = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   hazard_scoreboard_if #(.TW(3), .SW(2)) bus ();

   hazard_scoreboard #(.NSTAGE(3), .TW(3), .MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %-12s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drv(input logic [4:0] rs, input logic [2:0] rsu,
                      input logic [4:0] rt, input logic [2:0] rtu,
                      input logic [4:0] wa, input logic we, input logic [2:0] tn);
      bus.d_rs_addr = rs;
      bus.d_rs_tuse = rsu;
      bus.d_rt_addr = rt;
      bus.d_rt_tuse = rtu;
      bus.d_wa      = wa;
      bus.d_we      = we;
      bus.d_tnew    = tn;
   endtask

   task automatic drv_md(input logic st, input logic dv, input logic us);
      bus.d_md_start = st;
      bus.d_md_div   = dv;
      bus.d_md_use   = us;
   endtask

   task automatic idle();
      drv(5'd0, 3'd5, 5'd0, 3'd5, 5'd0, 1'b0, 3'd0);
      drv_md(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      settle();
      chk("rst_stall", bus.stall, 0);
      chk("rst_fwd_rs", bus.fwd_rs_sel, 0);
      chk("rst_efwd_rt", bus.e_fwd_rt_sel, 0);
      chk("rst_busy", bus.md_busy, 0);

      // addu $1 enters E with tnew 2; beq $1 (tuse 0) waits until tnew reaches 0 at stage 3
      drv(5'd0, 3'd5, 5'd0, 3'd5, 5'd1, 1'b1, 3'd2);
      settle();
      chk("t1_issue", bus.stall, 0);
      tick();
      drv(5'd1, 3'd0, 5'd0, 3'd0, 5'd0, 1'b0, 3'd0);
      settle();
      chk("t1_stall_a", bus.stall, 1);
      tick();
      chk("t1_stall_b", bus.stall, 1);
      tick();
      chk("t1_release", bus.stall, 0);
      chk("t1_fwd_rs", bus.fwd_rs_sel, 3);
      tick();

      // lw $2 (tnew 3); addu $3,$2,$2 (tuse 1) stalls twice then E-forwards from stage 3
      drv(5'd0, 3'd5, 5'd0, 3'd5, 5'd2, 1'b1, 3'd3);
      tick();
      drv(5'd2, 3'd1, 5'd2, 3'd1, 5'd3, 1'b1, 3'd1);
      settle();
      chk("t2_stall_a", bus.stall, 1);
      tick();
      chk("t2_stall_b", bus.stall, 1);
      tick();
      chk("t2_release", bus.stall, 0);
      chk("t2_dfwd_rs", bus.fwd_rs_sel, 0);
      chk("t2_efwd_pre", bus.e_fwd_rs_sel, 0);
      tick();
      idle();
      settle();
      chk("t2_efwd_rs", bus.e_fwd_rs_sel, 3);
      chk("t2_efwd_rt", bus.e_fwd_rt_sel, 3);
      tick();
      chk("t2_efwd_clr", bus.e_fwd_rs_sel, 0);

      // writes to $0 never create a scoreboard match
      drv(5'd0, 3'd5, 5'd0, 3'd5, 5'd0, 1'b1, 3'd1);
      tick();
      drv(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 1'b0, 3'd0);
      settle();
      chk("t3_stall", bus.stall, 0);
      chk("t3_fwd_rs", bus.fwd_rs_sel, 0);
      chk("t3_fwd_rt", bus.fwd_rt_sel, 0);

      // $5 ready in both E and M: nearest stage wins; unused operand never forwards
      drv(5'd0, 3'd5, 5'd0, 3'd5, 5'd5, 1'b1, 3'd1);
      tick();
      drv(5'd0, 3'd5, 5'd0, 3'd5, 5'd5, 1'b1, 3'd0);
      tick();
      drv(5'd5, 3'd0, 5'd5, 3'd2, 5'd0, 1'b0, 3'd0);
      settle();
      chk("t4_stall", bus.stall, 0);
      chk("t4_fwd_rs", bus.fwd_rs_sel, 1);
      chk("t4_fwd_rt", bus.fwd_rt_sel, 1);
      bus.d_rt_tuse = 3'd5;
      settle();
      chk("t4_unused", bus.fwd_rt_sel, 0);
      tick();

      // tnew 2 stalls even a late user (tuse 3); afterwards E-forward from stage 2
      drv(5'd0, 3'd5, 5'd0, 3'd5, 5'd6, 1'b1, 3'd2);
      tick();
      drv(5'd6, 3'd3, 5'd0, 3'd5, 5'd0, 1'b0, 3'd0);
      settle();
      chk("t4_late_stl", bus.stall, 1);
      tick();
      chk("t4_late_rel", bus.stall, 0);
      tick();
      idle();
      settle();
      chk("t4_efwd_rs", bus.e_fwd_rs_sel, 2);
      tick();
      tick();
      tick();

      // div then mflo: stall held for exactly DIV_LAT cycles when the MDU is built
      drv_md(1'b1, 1'b1, 1'b1);
      settle();
      chk("t5_div_iss", bus.stall, 0);
      tick();
      drv_md(1'b0, 1'b0, 1'b1);
      settle();
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t5_div_%0d", i), bus.stall, MDU_ON);
         tick();
      end
      chk("t5_div_end", bus.stall, 0);
      chk("t5_busy_end", bus.md_busy, 0);

      // mult, then a non-stalled start while busy reloads MUL_LAT instead of decrementing
      drv_md(1'b1, 1'b0, 1'b1);
      tick();
      drv_md(1'b0, 1'b0, 1'b0);
      tick();
      chk("t5_mul_busy", bus.md_busy, MDU_ON);
      drv_md(1'b1, 1'b0, 1'b0);
      settle();
      chk("t5_ld_nostl", bus.stall, 0);
      tick();
      drv_md(1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      tick();
      chk("t5_reload", bus.md_busy, MDU_ON);
      tick();
      chk("t5_mul_done", bus.md_busy, 0);

      // reset mid-divide at md_cnt 4 with a live scoreboard entry
      drv_md(1'b1, 1'b1, 1'b0);
      tick();
      drv_md(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      drv(5'd0, 3'd5, 5'd0, 3'd5, 5'd8, 1'b1, 3'd0);
      tick();
      drv(5'd8, 3'd0, 5'd0, 3'd5, 5'd0, 1'b0, 3'd0);
      drv_md(1'b0, 1'b0, 1'b1);
      settle();
      chk("t6_pre_busy", bus.md_busy, MDU_ON);
      chk("t6_pre_stall", bus.stall, MDU_ON);
      chk("t6_pre_fwd", bus.fwd_rs_sel, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      chk("t6_busy", bus.md_busy, 0);
      chk("t6_stall", bus.stall, 0);
      chk("t6_fwd_rs", bus.fwd_rs_sel, 0);
      chk("t6_efwd_rs", bus.e_fwd_rs_sel, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
